// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: M-stage load/store unit in front of an SRAM-like data bus.
// It decodes the M-stage opcode and address into bus requests and replicates
// store data with byte strobes. It flags misaligned loads and stores, and it
// stalls the pipeline while a bus transaction is outstanding. It returns the
// aligned, sign- or zero-extended load word on readdataM.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   opM, aluoutM          M-stage opcode and effective address
//   writedataM            store source value
//   flush_i               M-stage instruction cancelled
//   stall_ext             pipeline held by another unit
//   stallM                hold pipeline for memory access
//   readdataM             formatted load result (valid in DONE)
//   adel_rdM, adesM       load / store address error (combinational)
//   bus_err               one-cycle pulse when a WAIT times out
//   data_req..data_wstrb  bus request side
//   data_addr_ok, data_data_ok, data_rdata  bus response side
module mem_access_ctrl #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  input  logic        flush_i,
  input  logic        stall_ext,
  output logic        stallM,
  output logic [31:0] readdataM,
  output logic        adel_rdM,
  output logic        adesM,
  output logic        bus_err,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  output logic [3:0]  data_wstrb,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  localparam int          CNT_W  = (TIMEOUT_CYC > 255) ? $clog2(TIMEOUT_CYC + 1) : 8;
  localparam logic [31:0] TO_LIM = TIMEOUT_CYC;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_DRAIN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       op_q, op_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic [1:0]       size_q, size_d;
  logic             wr_q, wr_d;
  logic [31:0]      rword_q, rword_d;
  logic [5:0]       rop_q, rop_d;
  logic [1:0]       ra_q, ra_d;
  logic             bus_err_q, bus_err_d;

  logic        is_lb, is_lbu, is_lh, is_lhu, is_lw, is_sb, is_sh, is_sw;
  logic        is_load, is_store, need, timeout_hit, fin;
  logic [31:0] fin_word;

  function automatic logic [31:0] fmt_load(input logic [5:0] op, input logic [1:0] a,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (op)
      OP_LB:   return {{24{b[7]}}, b};
      OP_LBU:  return {24'h0, b};
      OP_LH:   return {{16{h[15]}}, h};
      OP_LHU:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  assign is_lb    = (opM == OP_LB);
  assign is_lbu   = (opM == OP_LBU);
  assign is_lh    = (opM == OP_LH);
  assign is_lhu   = (opM == OP_LHU);
  assign is_lw    = (opM == OP_LW);
  assign is_sb    = (opM == OP_SB);
  assign is_sh    = (opM == OP_SH);
  assign is_sw    = (opM == OP_SW);
  assign is_load  = is_lb | is_lbu | is_lh | is_lhu | is_lw;
  assign is_store = is_sb | is_sh | is_sw;

  assign adel_rdM = ~flush_i & ((((is_lh | is_lhu) & aluoutM[0])) | (is_lw & (|aluoutM[1:0])));
  assign adesM    = ~flush_i & ((is_sh & aluoutM[0]) | (is_sw & (|aluoutM[1:0])));
  assign need     = (is_load | is_store) & ~adel_rdM & ~adesM & ~flush_i;

  // Fires in the WAIT cycle whose increment would reach the limit, so the
  // abort happens after exactly TIMEOUT_CYC WAIT cycles.
  assign timeout_hit = (TIMEOUT_CYC != 0) && ((32'(cnt_q) + 32'd1) >= TO_LIM);

  assign readdataM  = fmt_load(rop_q, ra_q, rword_q);
  assign bus_err    = bus_err_q;
  assign data_wr    = wr_q;
  assign data_size  = size_q;
  assign data_addr  = addr_q;
  assign data_wdata = wdata_q;
  assign data_wstrb = wstrb_q;

  // Next-state and request decode
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    size_d    = size_q;
    wr_d      = wr_q;
    rword_d   = rword_q;
    rop_d     = rop_q;
    ra_d      = ra_q;
    bus_err_d = 1'b0;
    stallM    = 1'b0;
    data_req  = 1'b0;
    fin       = 1'b0;
    fin_word  = data_rdata;

    case (state_q)
      S_IDLE: begin
        stallM = need;
        if (need) begin
          state_d = S_REQ;
          cnt_d   = '0;
          op_d    = opM;
          addr_d  = aluoutM;
          wr_d    = is_store;
          size_d  = (is_lw | is_sw) ? 2'b10 : ((is_lh | is_lhu | is_sh) ? 2'b01 : 2'b00);
          wdata_d = is_sb ? {4{writedataM[7:0]}} :
                    is_sh ? {2{writedataM[15:0]}} :
                    is_sw ? writedataM : 32'h0;
          wstrb_d = is_sb ? (4'b0001 << aluoutM[1:0]) :
                    is_sh ? (aluoutM[1] ? 4'b1100 : 4'b0011) :
                    is_sw ? 4'b1111 : 4'b0000;
        end
      end
      S_REQ: begin
        stallM   = 1'b1;
        data_req = 1'b1;
        if (data_addr_ok) begin
          // An accepted request that is then cancelled still owes a response.
          if (data_data_ok) begin
            state_d = flush_i ? S_IDLE : S_DONE;
            fin     = ~flush_i;
          end else begin
            state_d = flush_i ? S_DRAIN : S_WAIT;
          end
        end else if (flush_i) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        stallM = 1'b1;
        cnt_d  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        if (data_data_ok) begin
          state_d = flush_i ? S_IDLE : S_DONE;
          fin     = ~flush_i;
        end else if (flush_i) begin
          state_d = S_DRAIN;
        end else if (timeout_hit) begin
          state_d   = S_DONE;
          fin       = 1'b1;
          fin_word  = 32'h0;
          bus_err_d = 1'b1;
        end
      end
      S_DRAIN: begin
        stallM = 1'b1;
        if (data_data_ok) state_d = S_IDLE;
      end
      S_DONE: begin
        if (!stall_ext) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Stores complete through DONE but leave the load result untouched.
    if (fin && !wr_q) begin
      rword_d = fin_word;
      rop_d   = op_q;
      ra_d    = addr_q[1:0];
    end
  end

  // State and captured-request registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      size_q    <= '0;
      wr_q      <= 1'b0;
      rword_q   <= '0;
      rop_q     <= '0;
      ra_q      <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      size_q    <= size_d;
      wr_q      <= wr_d;
      rword_q   <= rword_d;
      rop_q     <= rop_d;
      ra_q      <= ra_d;
      bus_err_q <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  localparam logic [5:0] LB  = 6'b100000;
  localparam logic [5:0] LBU = 6'b100100;
  localparam logic [5:0] LH  = 6'b100001;
  localparam logic [5:0] LHU = 6'b100101;
  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] SB  = 6'b101000;
  localparam logic [5:0] SH  = 6'b101001;
  localparam logic [5:0] SW  = 6'b101011;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opM;
  logic [31:0] aluoutM, writedataM, data_rdata;
  logic        flush_i, stall_ext, data_addr_ok, data_data_ok;
  logic        stallM, adel_rdM, adesM, bus_err, data_req, data_wr;
  logic [31:0] readdataM, data_addr, data_wdata;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] last_rd = 32'h0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst), .opM(opM), .aluoutM(aluoutM), .writedataM(writedataM),
    .flush_i(flush_i), .stall_ext(stall_ext), .stallM(stallM), .readdataM(readdataM),
    .adel_rdM(adel_rdM), .adesM(adesM), .bus_err(bus_err), .data_req(data_req),
    .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_wstrb(data_wstrb), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one M-stage op from IDLE while acting as the bus slave:
  // addr_ok after a_lat REQ cycles, data_ok d_lat WAIT cycles later
  // (same cycle as addr_ok when d_lat is 0).
  task automatic mem_op(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rdata, input int a_lat, input int d_lat);
    bit          is_ld, is_st, misal, need, accepted, delivered, done, first, sgn;
    int          bytes, req_wait, wait_n, n_stall, n_req, exp_stall, exp_req;
    logic [31:0] exp_wdata, v;
    logic [3:0]  exp_wstrb;
    logic [1:0]  exp_size;

    opM = op; aluoutM = addr; writedataM = wd; data_rdata = rdata;
    data_addr_ok = 1'b0; data_data_ok = 1'b0;

    is_ld = (op == LB) || (op == LBU) || (op == LH) || (op == LHU) || (op == LW);
    is_st = (op == SB) || (op == SH) || (op == SW);
    bytes = (op == LB || op == LBU || op == SB) ? 1 :
            (op == LH || op == LHU || op == SH) ? 2 : (op == LW || op == SW) ? 4 : 0;
    misal = (bytes != 0) && ((addr % bytes) != 0);
    need  = (is_ld || is_st) && !misal;
    exp_size  = (bytes == 1) ? 2'd0 : (bytes == 2) ? 2'd1 : 2'd2;
    exp_wstrb = is_st ? 4'(((1 << bytes) - 1) << (addr % 4)) : 4'h0;
    exp_wdata = (bytes == 1) ? (wd & 32'hFF) * 32'h0101_0101 :
                (bytes == 2) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
    exp_stall = need ? (2 + a_lat + d_lat) : 0;
    exp_req   = need ? (a_lat + 1) : 0;

    if (need && is_ld) begin
      v   = rdata >> ((addr % 4) * 8);
      sgn = (op == LB) || (op == LH);
      if (bytes == 1) begin
        v = v & 32'hFF;
        if (sgn && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end else if (bytes == 2) begin
        v = v & 32'hFFFF;
        if (sgn && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end
      last_rd = v;
    end

    req_wait = 0; wait_n = 0; accepted = 0; delivered = 0;
    n_stall = 0; n_req = 0; done = 0; first = 1;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if (cyc != 0) step();
      data_addr_ok = 1'b0; data_data_ok = 1'b0;
      if (data_req) begin
        if (req_wait < a_lat) req_wait++;
        else begin
          data_addr_ok = 1'b1; accepted = 1; wait_n = 0;
          if (d_lat == 0) begin data_data_ok = 1'b1; delivered = 1; end
        end
      end else if (accepted && !delivered) begin
        wait_n++;
        if (wait_n == d_lat) begin data_data_ok = 1'b1; delivered = 1; end
      end
      #1;
      if (first) begin
        chk("adel_rdM", 32'(adel_rdM), 32'(is_ld && misal));
        chk("adesM", 32'(adesM), 32'(is_st && misal));
        first = 0;
      end
      if (data_req && n_req == 0) begin
        chk("data_addr", data_addr, addr);
        chk("data_wr", 32'(data_wr), 32'(is_st));
        chk("data_size", 32'(data_size), 32'(exp_size));
        chk("data_wstrb", 32'(data_wstrb), 32'(exp_wstrb));
        if (is_st) chk("data_wdata", data_wdata, exp_wdata);
      end
      if (data_req) n_req++;
      if (stallM) n_stall++;
      else done = 1;
    end
    chk("op_completes", 32'(done), 32'd1);
    chk("stall_cycles", 32'(n_stall), 32'(exp_stall));
    chk("req_cycles", 32'(n_req), 32'(exp_req));
    chk("readdataM", readdataM, last_rd);
    step();
    opM = 6'h0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
  endtask

  initial begin
    logic [5:0]  ops [9];
    logic [31:0] ra, rw, rr;

    ops = '{LB, LBU, LH, LHU, LW, SB, SH, SW, 6'b001000};
    rst = 1'b1; opM = 6'h0; aluoutM = 32'h0; writedataM = 32'h0; data_rdata = 32'h0;
    flush_i = 1'b0; stall_ext = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stallM", 32'(stallM), 32'd0);
    chk("rst_readdataM", readdataM, 32'h0);
    chk("rst_data_req", 32'(data_req), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_data_addr", data_addr, 32'h0);
    chk("rst_data_wstrb", 32'(data_wstrb), 32'd0);
    rst = 1'b0;
    step();

    // directed loads / stores
    mem_op(LW,  32'h0000_1004, 32'h0, 32'h8765_4321, 0, 2);
    mem_op(LB,  32'h0000_2003, 32'h0, 32'h80FF_FF7F, 0, 1);
    mem_op(LBU, 32'h0000_2003, 32'h0, 32'h80FF_FF7F, 1, 0);
    mem_op(LH,  32'h0000_2002, 32'h0, 32'h80FF_FF7F, 0, 1);
    mem_op(SH,  32'h0000_3002, 32'h1234_ABCD, 32'h0, 0, 1);
    mem_op(SB,  32'h0000_3001, 32'h1234_ABCD, 32'h0, 0, 0);
    mem_op(LW,  32'h0000_4002, 32'h0, 32'h1111_1111, 0, 1);
    mem_op(SH,  32'h0000_4001, 32'h5555_6666, 32'h0, 0, 1);

    // flush while request not yet accepted drops it
    opM = SW; aluoutM = 32'h0000_0040; writedataM = 32'hCAFE_0001;
    step();
    flush_i = 1'b1;
    #1;
    chk("req_before_flush", 32'(data_req), 32'd1);
    step();
    flush_i = 1'b0; opM = 6'h0;
    #1;
    chk("req_dropped", 32'(data_req), 32'd0);
    chk("req_dropped_stall", 32'(stallM), 32'd0);

    // flush in WAIT: drain the outstanding read, discard it
    opM = LW; aluoutM = 32'h0000_2000;
    #1;
    chk("flush_idle_stall", 32'(stallM), 32'd1);
    step();
    data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0; flush_i = 1'b1;
    #1;
    chk("flush_wait_stall", 32'(stallM), 32'd1);
    step();
    flush_i = 1'b0; opM = 6'h0;
    #1;
    chk("drain_stall_1", 32'(stallM), 32'd1);
    step();
    data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
    #1;
    chk("drain_stall_2", 32'(stallM), 32'd1);
    step();
    data_data_ok = 1'b0;
    #1;
    chk("drain_discard", readdataM, last_rd);
    chk("drain_no_req", 32'(data_req), 32'd0);
    mem_op(LW, 32'h0000_2008, 32'h0, 32'h0BAD_F00D, 0, 1);

    // timeout after four WAIT cycles, then hold DONE with stall_ext
    opM = LW; aluoutM = 32'h0000_3000;
    step();
    data_addr_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      data_addr_ok = 1'b0;
      #1;
      chk("to_wait_stall", 32'(stallM), 32'd1);
      chk("to_wait_no_err", 32'(bus_err), 32'd0);
    end
    step();
    stall_ext = 1'b1;
    #1;
    last_rd = 32'h0;
    chk("to_bus_err", 32'(bus_err), 32'd1);
    chk("to_stallM", 32'(stallM), 32'd0);
    chk("to_readdataM", readdataM, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      #1;
      chk("hold_bus_err", 32'(bus_err), 32'd0);
      chk("hold_no_req", 32'(data_req), 32'd0);
      chk("hold_stallM", 32'(stallM), 32'd0);
      chk("hold_readdataM", readdataM, 32'h0);
    end
    stall_ext = 1'b0;
    step();
    opM = 6'h0;

    // randomized ops against the reference model
    for (int i = 0; i < 60; i++) begin
      ra = $urandom();
      rw = $urandom();
      rr = $urandom();
      mem_op(ops[$urandom_range(0, 8)], ra, rw, rr,
             int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory-stage load/store unit between the pipeline datapath and the data-side SRAM-like bus.
- Decodes the M-stage opcode and address into bus requests, replicates store data and generates byte strobes.
- Detects load/store address errors and stalls the pipeline until the bus transaction completes.
- Returns aligned, sign- or zero-extended load data as readdataM.

Parameters:
- TIMEOUT_CYC, 255: max cycles waited in WAIT for data_ok before aborting with bus_err; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- opM  in  6  M-stage opcode.
- aluoutM  in  32  effective address.
- writedataM  in  32  store source register value.
- flush_i  in  1  M-stage instruction cancelled (exception/flushM).
- stall_ext  in  1  pipeline held by another source (e.g. divider).
- stallM  out  1  hold pipeline for memory access.
- readdataM  out  32  formatted load result.
- adel_rdM  out  1  load address error.
- adesM  out  1  store address error.
- bus_err  out  1  one-cycle timeout pulse.
- data_req  out  1  bus request.
- data_wr  out  1  1 = write.
- data_size  out  2  00 byte, 01 half, 10 word.
- data_addr  out  32  bus address.
- data_wdata  out  32  store data.
- data_wstrb  out  4  byte strobes.
- data_addr_ok  in  1  request accepted.
- data_data_ok  in  1  read data valid / write done.
- data_rdata  in  32  raw read word.

Behaviour:
- Decode (combinational):
  - Loads: lb 100000, lbu 100100, lh 100001, lhu 100101, lw 100011.
  - Stores: sb 101000, sh 101001, sw 101011.
  - Any other op is not a memory op.
- Address errors (combinational, not registered):
  - adel_rdM = (lh|lhu) & a[0], or lw & (a[1:0]!=0).
  - adesM = sh & a[0], or sw & (a[1:0]!=0).
  - Both are forced 0 when flush_i=1.
  - An erroneous access never issues a bus request.
- need = memop & ~adel_rdM & ~adesM & ~flush_i.
- FSM states: IDLE, REQ, WAIT, DONE, DRAIN. Reset enters IDLE.
- IDLE:
  - need=1 -> REQ.
  - stallM = need.
- REQ:
  - data_req=1; addr/size/wr/wdata/wstrb are driven from registers captured on entry to REQ.
  - addr_ok & data_ok in the same cycle -> DONE, latch rdata.
  - addr_ok only -> WAIT.
  - flush_i with no addr_ok -> IDLE, request dropped.
  - stallM=1.
- WAIT:
  - data_req=0; cycle counter increments each cycle.
  - data_ok -> DONE, latch rdata.
  - flush_i -> DRAIN.
  - counter == TIMEOUT_CYC (nonzero) -> DONE, latched word = 0, bus_err=1 for one cycle.
  - stallM=1.
- DRAIN:
  - Wait for data_ok, discard the data, -> IDLE.
  - stallM=1, so no new request can overlap an outstanding one.
- DONE:
  - stallM=0; readdataM is valid.
  - stall_ext=1 -> stay in DONE, holding data with no reissue.
  - Otherwise -> IDLE next cycle, as the pipeline advances.
- Bus fields:
  - data_addr = {a[31:2], a[1:0]}, full address.
  - sb: wdata = {4{wd[7:0]}}, wstrb = 0001 << a[1:0].
  - sh: wdata = {2{wd[15:0]}}, wstrb = a[1] ? 1100 : 0011.
  - sw: wstrb = 1111.
  - Loads: wstrb = 0000, wr = 0.
- Load format (from latched word w and captured a[1:0]):
  - lb/lbu select byte a[1:0], sign/zero extend.
  - lh/lhu select half a[1], sign/zero extend.
  - lw passes w through.
  - Formatting is done combinationally from registers; readdataM holds its last value outside DONE.
- Stores also go through DONE; readdataM is unchanged for stores.
- Reset values:
  - All outputs 0, state IDLE, counter 0, latched word 0.
  - Async reset mid-transaction abandons it; the bus side must be reset together with this block.
- Counter width is 8 bits minimum and saturates, never wrapping. It is cleared on entry to REQ.

Test Plan:
- lw at 0x0000_1004, addr_ok cycle 1, data_ok cycle 3 with rdata 0x8765_4321:
  - stallM high 4 cycles, data_req high only in REQ, readdataM=0x8765_4321 in DONE.
- lb at 0x...03 and lbu at 0x...03 with rdata 0x80FF_FF7F:
  - lb readdataM=0xFFFF_FF80, lbu readdataM=0x0000_0080.
  - lh at 0x...02 readdataM=0xFFFF_80FF.
- sh at 0x...02 with writedataM=0x1234_ABCD:
  - data_wr=1, size=01, wdata=0xABCD_ABCD, wstrb=1100.
  - sb at 0x...01: wstrb=0010.
- lw at 0x...02 and sh at 0x...01:
  - adel_rdM=1 and adesM=1 respectively, data_req never asserted, stallM=0.
- flush_i asserted in WAIT:
  - DRAIN, stallM stays 1 until data_ok, data discarded, next op issues afterwards.
- TIMEOUT_CYC=4, no data_ok:
  - bus_err pulses after 4 WAIT cycles, readdataM=0.
  - stall_ext=1 in DONE holds the state 3 cycles with no second request.
